uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_tx` byte transmitter among `N_REQ` independent byte producers. It sits between the requesters (command responder, debug logger, loopback echo of `uart_rx`) and the single serialiser, using the same valid/ready byte handshake as the UART datapath on both sides. It is optionally packet-aware: a requester can hold the transmitter until it marks a byte as its last.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART datapath constants, arbiter state encoding and pointer width helper.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, SEND, HOLD} uart_arb_state_t;
  function automatic int uart_ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin pick of the first request at or after the pointer, with wrap.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = uart_ptr_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx
);
  logic [PW-1:0] w_j;
  logic          w_found;
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < N; k++) begin
      w_j = PW'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_j]) begin
        w_found      = 1'b1;
        o_idx        = w_j;
        o_grant[w_j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx among N_REQ byte producers.
// Define UART_ARB_LOCK_EN for packet locking (HOLD state, req_last_i, lock timeout).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = UART_DATA_W,
  parameter int LOCK_TIMEOUT = 1_000_000
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [N_REQ*DATA_W-1:0]    req_data_i,
  input  logic [N_REQ-1:0]           req_last_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic                       tx_valid_o,
  output logic [DATA_W-1:0]          tx_data_o,
  input  logic                       tx_ready_i,
  output logic [$clog2(N_REQ)-1:0]   grant_id_o,
  output logic                       busy_o,
  output logic                       timeout_o
);
  localparam int PW = uart_ptr_w(N_REQ);
  uart_arb_state_t   r_state;
  logic [PW-1:0]     r_rr_ptr;
  logic [PW-1:0]     r_gid;
  logic [DATA_W-1:0] r_data;
  logic              r_tx_valid;
  logic              r_busy;
  logic [N_REQ-1:0]  w_pick;
  logic [PW-1:0]     w_pick_idx;
  logic [PW-1:0]     w_sel;
  logic [PW-1:0]     w_next_ptr;
  logic              w_accept;
  logic [DATA_W-1:0] w_bytes [N_REQ];

  for (genvar n = 0; n < N_REQ; n++) begin : g_bytes
    assign w_bytes[n] = req_data_i[n*DATA_W +: DATA_W];
  end

  uart_rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .i_req   (req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick),
    .o_idx   (w_pick_idx)
  );

  assign w_sel      = (r_state == IDLE) ? w_pick_idx : r_gid;
  assign w_next_ptr = (r_gid == PW'(N_REQ - 1)) ? '0 : r_gid + 1'b1;
  assign w_accept   = |req_ready_o;
  assign tx_valid_o = r_tx_valid;
  assign tx_data_o  = r_data;
  assign grant_id_o = r_gid;
  assign busy_o     = r_busy;

`ifdef UART_ARB_LOCK_EN
  localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  logic [CW-1:0] r_cnt;
  logic          r_last;
  logic          r_timeout;
  // HOLD only listens to the current owner; everyone else waits for release.
  assign req_ready_o = (r_state == IDLE) ? w_pick :
                       (r_state == HOLD && req_valid_i[r_gid]) ? (N_REQ'(1) << r_gid) : '0;
  assign timeout_o   = r_timeout;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_gid      <= '0;
      r_data     <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
      r_last     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      r_cnt     <= (r_state == HOLD && !w_accept) ? ((&r_cnt) ? r_cnt : r_cnt + 1'b1) : '0;
      if (w_accept) begin
        r_state    <= SEND;
        r_tx_valid <= 1'b1;
        r_busy     <= 1'b1;
        r_data     <= w_bytes[w_sel];
        r_gid      <= w_sel;
        r_last     <= req_last_i[w_sel];
      end else if (r_state == SEND && tx_ready_i) begin
        r_tx_valid <= 1'b0;
        r_state    <= r_last ? IDLE : HOLD;
        r_busy     <= !r_last;
        if (r_last) r_rr_ptr <= w_next_ptr;
      end else if (r_state == HOLD && r_cnt == CW'(LOCK_TIMEOUT - 1)) begin
        r_timeout <= 1'b1;
        r_state   <= IDLE;
        r_busy    <= 1'b0;
        r_rr_ptr  <= w_next_ptr;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused    = ^{req_last_i, 1'(LOCK_TIMEOUT % 2)};
  assign req_ready_o = (r_state == IDLE) ? w_pick : '0;
  assign timeout_o   = 1'b0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_gid      <= '0;
      r_data     <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else if (w_accept) begin
      r_state    <= SEND;
      r_tx_valid <= 1'b1;
      r_busy     <= 1'b1;
      r_data     <= w_bytes[w_sel];
      r_gid      <= w_sel;
    end else if (r_state == SEND && tx_ready_i) begin
      r_state    <= IDLE;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_rr_ptr   <= w_next_ptr;
    end
  end
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration order, backpressure, reset and (with UART_ARB_LOCK_EN) locking.
module tb_uart_tx_arbiter;
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [3:0]  req_valid_i = '0;
  logic [31:0] req_data_i = '0;
  logic [3:0]  req_last_i = '0;
  logic [3:0]  req_ready_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i = 1'b0;
  logic [1:0]  grant_id_o;
  logic        busy_o;
  logic        timeout_o;
  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .LOCK_TIMEOUT(20)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .grant_id_o  (grant_id_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    tick();
    chk("rst_tx_valid", tx_valid_o, 0);
    chk("rst_tx_data", tx_data_o, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_gid", grant_id_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_timeout", timeout_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    tick();
    // single requester
    req_valid_i = 4'b0100;
    req_data_i  = 32'h0095_0000;
    tx_ready_i  = 1'b1;
    #1;
    chk("single_ready", req_ready_o, 4'b0100);
    chk("single_pre_valid", tx_valid_o, 0);
    tick();
    req_valid_i = 4'b0000;
    #1;
    chk("single_tx_valid", tx_valid_o, 1);
    chk("single_tx_data", tx_data_o, 8'h95);
    chk("single_gid", grant_id_o, 2);
    chk("single_busy", busy_o, 1);
    chk("single_send_ready", req_ready_o, 0);
    tick();
    chk("single_done_valid", tx_valid_o, 0);
    chk("single_done_busy", busy_o, 0);
    // all requesters valid, round-robin from pointer 0
    do_reset();
    req_valid_i = 4'b1111;
    req_data_i  = 32'h1312_1110;
    tx_ready_i  = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("rr_ready", req_ready_o, 4'b0001 << (i % 4));
      tick();
      chk("rr_valid", tx_valid_o, 1);
      chk("rr_data", tx_data_o, 8'h10 + (i % 4));
      chk("rr_gid", grant_id_o, i % 4);
      chk("rr_send_ready", req_ready_o, 0);
      tick();
    end
    // backpressure
    tx_ready_i = 1'b0;
    #1;
    chk("bp_ready0", req_ready_o, 4'b0001);
    tick();
    for (int i = 0; i < 50; i++) begin
      chk("bp_valid", tx_valid_o, 1);
      chk("bp_data", tx_data_o, 8'h10);
      chk("bp_ready", req_ready_o, 0);
      tick();
    end
    tx_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", req_ready_o, 0);
    tick();
    chk("bp_done_valid", tx_valid_o, 0);
    chk("bp_next_ready", req_ready_o, 4'b0010);
`ifdef UART_ARB_LOCK_EN
    // locked packet from requester 1 while requester 0 waits
    do_reset();
    tx_ready_i  = 1'b1;
    req_valid_i = 4'b0010;
    req_last_i  = 4'b0000;
    req_data_i  = 32'h0000_A1B0;
    #1;
    chk("lk_ready1", req_ready_o, 4'b0010);
    tick();
    req_valid_i = 4'b0011;
    #1;
    chk("lk_data1", tx_data_o, 8'hA1);
    chk("lk_send_ready", req_ready_o, 0);
    tick();
    req_data_i[15:8] = 8'hA2;
    #1;
    chk("lk_hold_busy", busy_o, 1);
    chk("lk_hold_valid", tx_valid_o, 0);
    chk("lk_hold_ready", req_ready_o, 4'b0010);
    tick();
    req_data_i[15:8] = 8'hA3;
    req_last_i = 4'b0010;
    #1;
    chk("lk_data2", tx_data_o, 8'hA2);
    tick();
    chk("lk_hold_ready2", req_ready_o, 4'b0010);
    tick();
    chk("lk_data3", tx_data_o, 8'hA3);
    tick();
    chk("lk_release_ready", req_ready_o, 4'b0001);
    tick();
    chk("lk_r0_data", tx_data_o, 8'hB0);
    chk("lk_r0_gid", grant_id_o, 0);
    // lock timeout
    do_reset();
    req_last_i  = 4'b0000;
    req_valid_i = 4'b0010;
    tick();
    req_valid_i = 4'b0001;
    tick();
    for (int i = 0; i < 19; i++) begin
      chk("to_wait_pulse", timeout_o, 0);
      chk("to_wait_ready", req_ready_o, 0);
      tick();
    end
    chk("to_last_hold_busy", busy_o, 1);
    chk("to_last_hold_pulse", timeout_o, 0);
    tick();
    chk("to_pulse", timeout_o, 1);
    chk("to_busy", busy_o, 0);
    chk("to_ready", req_ready_o, 4'b0001);
    tick();
    chk("to_pulse_end", timeout_o, 0);
    chk("to_r0_data", tx_data_o, 8'hB0);
    chk("to_r0_gid", grant_id_o, 0);
`endif
    // reset mid-SEND
    req_last_i  = 4'b0000;
    req_valid_i = 4'b1111;
    req_data_i  = 32'h1312_1110;
    tx_ready_i  = 1'b0;
    tick();
    tick();
    chk("ms_valid", tx_valid_o, 1);
    reset_i = 1'b1;
    #1;
    chk("ms_async_valid", tx_valid_o, 0);
    chk("ms_async_busy", busy_o, 0);
    chk("ms_async_gid", grant_id_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    chk("ms_first_ready", req_ready_o, 4'b0001);
    tick();
    chk("ms_first_gid", grant_id_o, 0);
    chk("ms_first_data", tx_data_o, 8'h10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
